// File: rtl/mag15_serial.sv
// Bit-serial unsigned magnitude comparator: scans A/B from MSB down, one bit per
// clock, stopping at the first differing bit. start/busy/done handshake.
module mag15_serial #(
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AgtB,
  output logic             AeqB,
  output logic             AltB
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_flags;   // {AgtB, AeqB, AltB}

  logic             w_a_bit;
  logic             w_b_bit;

  assign w_a_bit = r_a[r_idx];
  assign w_b_bit = r_b[r_idx];

  // Operand registers are left out of reset; they are only read in SCAN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_flags <= 3'b000;
      r_idx   <= IW'(WIDTH - 1);
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_idx   <= IW'(WIDTH - 1);
            r_flags <= 3'b000;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (w_a_bit != w_b_bit) begin
            r_flags <= w_a_bit ? 3'b100 : 3'b001;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_idx == IW'(0)) begin
            r_flags <= 3'b010;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign AgtB = r_flags[2];
  assign AeqB = r_flags[1];
  assign AltB = r_flags[0];

endmodule

// File: tb/tb_mag15_serial.sv
// Scoreboard bench for mag15_serial: expected flags and completion cycle are
// queued at each accept and checked when done pulses.
module tb_mag15_serial;

  localparam int unsigned W = 15;

  typedef struct {
    logic [2:0] flags;
    int         cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy, done, agtb, aeqb, altb;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;
  exp_t sb_q[$];

  mag15_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .busy  (busy),
    .done  (done),
    .AgtB  (agtb),
    .AeqB  (aeqb),
    .AltB  (altb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: first differing bit from the MSB decides; equal takes all W cycles.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int e0);
    exp_t r;
    r.flags = 3'b010;
    r.cyc   = e0 + W;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        r.flags = a[i] ? 3'b100 : 3'b001;
        r.cyc   = e0 + W - i;
        break;
      end
    end
    return r;
  endfunction

  // Called #1 after an edge where the DUT accepts; cyc then equals that edge number.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    sb_q.push_back(model(a, b, cyc));
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    chk("idle_before_start", 32'(busy), 32'd0);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    push_exp(a, b);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: handshake invariants every cycle, scoreboard compare on done.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (busy) chk("flags_clear_busy", 32'({agtb, aeqb, altb}), 32'd0);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result_flags", 32'({agtb, aeqb, altb}), 32'(e.flags));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({agtb, aeqb, altb}), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // MSB differs: one-cycle scan.
    accept(15'h4000, 15'h3FFF);
    @(negedge clk);
    chk("msb_busy_1cyc", 32'(busy), 32'd1);
    drain(40);
    chk("msb_busy_after", 32'(busy), 32'd0);

    // Difference at bit 1.
    accept(15'd5, 15'd6);
    drain(40);

    // Equal operands, then flags must hold through idle.
    accept(15'h2A55, 15'h2A55);
    drain(40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("eq_hold_idle", 32'({agtb, aeqb, altb}), 32'b010);
    end

    // Ignored start pulse and operand churn during a scan.
    accept(15'h2A55, 15'h2A55);
    idle(3);
    start = 1'b1;
    a_in  = 15'h7FFF;
    b_in  = 15'h0000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in = 15'($urandom);
      b_in = 15'($urandom);
      @(negedge clk);
    end
    drain(40);

    // start held high: accepts on each DONE edge.
    @(negedge clk);
    start = 1'b1;
    a_in  = 15'h7FFF;
    b_in  = 15'h0000;
    @(posedge clk); #1; push_exp(15'h7FFF, 15'h0000);
    @(posedge clk);
    @(posedge clk); #1; push_exp(15'h7FFF, 15'h0000);
    @(negedge clk);
    a_in = 15'h0000;
    b_in = 15'h0001;
    @(posedge clk);
    @(posedge clk); #1; push_exp(15'h0000, 15'h0001);
    @(negedge clk);
    start = 1'b0;
    drain(40);

    // Reset mid-scan: no done, outputs cleared.
    accept(15'h2A55, 15'h2A55);
    sb_q.delete();
    idle(6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_flags", 32'({agtb, aeqb, altb}), 32'd0);
    idle(20);

    // Normal operation after reset, plus a few random compares.
    accept(15'h4000, 15'h3FFF);
    drain(40);
    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] ra, rb;
      ra = 15'($urandom);
      rb = (k % 3 == 0) ? ra : 15'($urandom);
      accept(ra, rb);
      drain(40);
    end

    idle(2);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mag15_serial.md
# mag15_serial

Sequential, bit-serial counterpart to the parallel 15-bit magnitude comparator. The parallel comparator resolves its cascade from LSB to MSB in one combinational pass. This block scans the other direction: MSB first, one bit per clock, stopping at the first differing bit. It sits beside the datapath wherever area matters more than latency, and uses a start/busy/done handshake.

## Interface
- WIDTH, 15, operand width; index counter is $clog2(WIDTH) bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous and active-low
- start  in  1  request a compare; accepted only when busy=0
- A  in  WIDTH  operand A; sampled only on the accepting edge
- B  in  WIDTH  operand B; sampled only on the accepting edge
- busy  out  1  high while state=SCAN
- done  out  1  one-cycle pulse; result flags are valid from this cycle
- AgtB  out  1  A>B (unsigned)
- AeqB  out  1  A==B
- AltB  out  1  A<B (unsigned)

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - on start=1: a_reg<=A, b_reg<=B, idx<=WIDTH-1, flags<=000, go to SCAN.
- SCAN, examines bit idx each cycle:
  - a_reg[idx]=1, b_reg[idx]=0: flags<=100 (AgtB), go to DONE.
  - a_reg[idx]=0, b_reg[idx]=1: flags<=001 (AltB), go to DONE.
  - bits equal and idx==0: flags<=010 (AeqB), go to DONE.
  - bits equal and idx>0: idx<=idx-1, stay in SCAN.
- DONE: lasts exactly one cycle with done=1.
  - start=1: treated as an IDLE accept; go straight to SCAN with new operands and clear the flags.
  - otherwise: go to IDLE.
- Flags: one-hot whenever valid. 000 means "no valid result": after reset, and from accept until done.
- Flags hold their value through IDLE until the next accepted start.
- start while busy=1 is ignored. It is not queued.
- Changes on A/B while busy are ignored, because the operands were captured at accept.
- Comparison is unsigned. idx never wraps: the idx==0 case always exits SCAN.
- busy and done are never high together.

## Timing
- Reset: when rst_n=0 at a rising edge, state=IDLE and busy=0, done=0, AgtB=AeqB=AltB=0, idx=WIDTH-1. Operand registers are don't-care.
  - Applies from any state, including mid-SCAN. The scan is aborted, with no done pulse.
- Accept edge E0 (start=1, busy=0): busy=1 after E0.
- First difference at bit i: resolved at edge E0+(WIDTH-i). After that edge, done=1, busy=0 and the flags are valid.
  - Latency range: 1 cycle (MSB differs) to WIDTH cycles (equal operands, or difference only at bit 0).
- done is high for exactly one cycle, then low unless a new compare finishes.
- Back-to-back: start held high through the DONE cycle is accepted on that edge. Flags clear to 000 on that edge.
- No combinational path from the inputs to any output; all outputs are registered.

## Test plan
- Reset, then A=15'h4000, B=15'h3FFF, start pulse: done one cycle after the accept edge, AgtB=1 and the others 0, busy high for 1 cycle.
- A=15'd5, B=15'd6: done 14 cycles after accept, AltB=1. Flags 000 throughout busy.
- A=B=15'h2A55: done 15 cycles after accept, AeqB=1. Flags held for 10 further idle cycles.
- During the 15-cycle equal compare, pulse start with different A/B and toggle the A/B inputs mid-scan: no effect, result still AeqB at cycle 15.
- Start held high continuously with A=15'h7FFF, B=0 then A=0, B=15'h0001: done pulses every 2 cycles. The first result is AgtB; the second, after 15 scan cycles, is AltB.
- rst_n=0 for one edge at scan cycle 7 of an equal compare: next cycle all outputs 0, no done pulse. A following compare works normally.
